rvseed_test_mon: RTL and testbench

- Synthesizable end-of-test monitor that sits downstream of the rvseed register-file write port. It snoops retiring register writes.
- Implements the ISA-test completion protocol:
  - Test end: x26 is written with 1.
  - Verdict: x27 == 1 means pass.
  - Failing test number: held in x3.
- Reports pass/fail, the failing test number, cycle and retire counts, and a timeout verdict.
- Lets benches and FPGA builds judge a test without hierarchical peeks into reg_f.

---
 rtl/rvseed_test_mon.sv | 141 ++++++++++++++
 tb/tb_rvseed_test_mon.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvseed_test_mon.sv
// rvseed_test_mon: end-of-test monitor on the rvseed register-file write port.
// It snoops retiring register writes and reports the verdict of an ISA test
// (x26 <- 1 ends the test, x27 == 1 means pass, x3 holds the test number),
// together with cycle/retire counts and a timeout verdict.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no test monitored, register writes ignored
// S_RUN    | test running, shadows tracking writes, timeout armed
// S_SETTLE | end seen, waiting SETTLE_CYC cycles for late result writes
// S_DONE   | verdict valid and held, counters frozen
module rvseed_test_mon #(
    parameter int CPU_WIDTH   = 32,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 500,
    parameter int SETTLE_CYC  = 1,
    parameter int END_REG     = 26,
    parameter int RES_REG     = 27,
    parameter int NUM_REG     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 reg_wen_i,
    input  logic [4:0]           reg_waddr_i,
    input  logic [CPU_WIDTH-1:0] reg_wdata_i,
    input  logic                 inst_retire_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic                 timeout_o,
    output logic [CPU_WIDTH-1:0] testnum_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [CNT_W-1:0]     retire_cnt_o
);

    localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE, S_DONE} state_t;

    state_t               r_state;
    logic [SW-1:0]        r_settle;
    logic [CPU_WIDTH-1:0] r_sh_num;
    logic [CPU_WIDTH-1:0] r_sh_res;

    logic                 w_active;
    logic                 w_wr;
    logic                 w_wr_num;
    logic                 w_wr_res;
    logic                 w_end;
    logic                 w_timeout;
    logic [CPU_WIDTH-1:0] w_num_fwd;
    logic [CPU_WIDTH-1:0] w_res_fwd;
    logic [CNT_W-1:0]     w_cyc_inc;
    logic [CNT_W-1:0]     w_ret_inc;
    logic [SW-1:0]        w_settle_dn;

    // Write decode, same-edge forwarding of shadows, saturating counter increments.
    always_comb begin
        w_active    = (r_state == S_RUN) || (r_state == S_SETTLE);
        w_wr        = reg_wen_i && (reg_waddr_i != 5'd0);
        w_wr_num    = w_wr && (reg_waddr_i == 5'(NUM_REG));
        w_wr_res    = w_wr && (reg_waddr_i == 5'(RES_REG));
        w_end       = w_wr && (reg_waddr_i == 5'(END_REG)) && (reg_wdata_i == CPU_WIDTH'(1));
        w_num_fwd   = w_wr_num ? reg_wdata_i : r_sh_num;
        w_res_fwd   = w_wr_res ? reg_wdata_i : r_sh_res;
        w_cyc_inc   = (&cycle_cnt_o) ? cycle_cnt_o : cycle_cnt_o + CNT_W'(1);
        w_ret_inc   = (&retire_cnt_o) ? retire_cnt_o
                    : retire_cnt_o + CNT_W'(inst_retire_i);
        w_timeout   = (r_state == S_RUN) && (w_cyc_inc == CNT_W'(TIMEOUT_CYC));
        w_settle_dn = r_settle - SW'(1);
    end

    // Monitor FSM with registered verdict, counters and shadows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_settle     <= '0;
            r_sh_num     <= '0;
            r_sh_res     <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
            fail_o       <= 1'b0;
            timeout_o    <= 1'b0;
            testnum_o    <= '0;
            cycle_cnt_o  <= '0;
            retire_cnt_o <= '0;
        end else if (start_i) begin
            // Restart wins over any end/timeout event on the same edge.
            r_state      <= S_RUN;
            r_settle     <= '0;
            r_sh_num     <= '0;
            r_sh_res     <= '0;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
            fail_o       <= 1'b0;
            timeout_o    <= 1'b0;
            testnum_o    <= '0;
            cycle_cnt_o  <= '0;
            retire_cnt_o <= '0;
        end else begin
            if (w_active) begin
                cycle_cnt_o  <= w_cyc_inc;
                retire_cnt_o <= w_ret_inc;
                if (w_wr_num) r_sh_num <= reg_wdata_i;
                if (w_wr_res) r_sh_res <= reg_wdata_i;
            end
            case (r_state)
                S_RUN: begin
                    // End detection outranks timeout on the same edge.
                    if (w_end) begin
                        r_state  <= S_SETTLE;
                        r_settle <= SW'(SETTLE_CYC);
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        fail_o    <= 1'b1;
                        timeout_o <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    r_settle <= w_settle_dn;
                    if (w_settle_dn == '0) begin
                        r_state   <= S_DONE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        pass_o    <= (w_res_fwd == CPU_WIDTH'(1));
                        fail_o    <= (w_res_fwd != CPU_WIDTH'(1));
                        testnum_o <= w_num_fwd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rvseed_test_mon.sv
// Directed bench for rvseed_test_mon: instance a uses SETTLE_CYC=1,
// instance b uses SETTLE_CYC=2, both share the same stimulus.
module tb_rvseed_test_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        retire;

    logic        a_busy, a_done, a_pass, a_fail, a_tmo;
    logic [31:0] a_num, a_cyc, a_ret;
    logic        b_busy, b_done, b_pass, b_fail, b_tmo;
    logic [31:0] b_num, b_cyc, b_ret;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rvseed_test_mon #(.SETTLE_CYC(1), .TIMEOUT_CYC(500)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(start), .reg_wen_i(wen),
        .reg_waddr_i(waddr), .reg_wdata_i(wdata), .inst_retire_i(retire),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .fail_o(a_fail),
        .timeout_o(a_tmo), .testnum_o(a_num), .cycle_cnt_o(a_cyc),
        .retire_cnt_o(a_ret)
    );

    rvseed_test_mon #(.SETTLE_CYC(2), .TIMEOUT_CYC(500)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(start), .reg_wen_i(wen),
        .reg_waddr_i(waddr), .reg_wdata_i(wdata), .inst_retire_i(retire),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .fail_o(b_fail),
        .timeout_o(b_tmo), .testnum_o(b_num), .cycle_cnt_o(b_cyc),
        .retire_cnt_o(b_ret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic verdict(input string tag, input logic d, input logic p,
                           input logic f, input logic t, input logic [31:0] num);
        chk({tag, ".done"}, a_done, d);
        chk({tag, ".pass"}, a_pass, p);
        chk({tag, ".fail"}, a_fail, f);
        chk({tag, ".timeout"}, a_tmo, t);
        chk({tag, ".testnum"}, a_num, num);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; retire = 1'b0;
        repeat (2) tick();
        chk("rst.busy", a_busy, 1'b0);
        verdict("rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("rst.cyc", a_cyc, 32'd0);
        chk("rst.ret", a_ret, 32'd0);
        rst = 1'b0;

        // idle filtering: end write and x0 writes must not start anything
        wr(5'd26, 32'd1);
        wr(5'd0, 32'd1);
        chk("idle.busy", a_busy, 1'b0);
        chk("idle.done", a_done, 1'b0);
        chk("idle.cyc", a_cyc, 32'd0);

        // pass
        pulse_start();
        chk("pass.busy0", a_busy, 1'b1);
        chk("pass.cyc0", a_cyc, 32'd0);
        retire = 1'b1;
        wr(5'd3, 32'd5);
        wr(5'd0, 32'd1);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        retire = 1'b0;
        chk("pass.settle_done", a_done, 1'b0);
        chk("pass.settle_busy", a_busy, 1'b1);
        tick();
        verdict("pass", 1'b1, 1'b1, 1'b0, 1'b0, 32'd5);
        chk("pass.busy", a_busy, 1'b0);
        chk("pass.cyc", a_cyc, 32'd5);
        chk("pass.ret", a_ret, 32'd4);
        chk("pass.b_done_early", b_done, 1'b0);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        chk("pass.b_done", b_done, 1'b1);
        chk("pass.b_pass", b_pass, 1'b1);
        chk("pass.freeze_cyc", a_cyc, 32'd5);
        chk("pass.freeze_ret", a_ret, 32'd4);
        wr(5'd26, 32'd1);
        chk("done.ignore_busy", a_busy, 1'b0);
        chk("done.ignore_done", a_done, 1'b1);

        // fail
        pulse_start();
        chk("fail.cleared", a_done, 1'b0);
        wr(5'd3, 32'd7);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        tick();
        verdict("fail", 1'b1, 1'b0, 1'b1, 1'b0, 32'd7);

        // late result, non-1 end write ignored
        pulse_start();
        wr(5'd26, 32'd2);
        repeat (3) tick();
        chk("late.no_end_a", a_done, 1'b0);
        chk("late.no_end_b", b_done, 1'b0);
        chk("late.busy", a_busy, 1'b1);
        wr(5'd26, 32'd1);
        wr(5'd27, 32'd1);
        verdict("late_a", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("late_a.cyc", a_cyc, 32'd6);
        chk("late.b_done_early", b_done, 1'b0);
        tick();
        chk("late.b_done", b_done, 1'b1);
        chk("late.b_pass", b_pass, 1'b1);
        chk("late.b_fail", b_fail, 1'b0);

        // timeout
        pulse_start();
        retire = 1'b1;
        repeat (499) tick();
        chk("tmo.pre_done", a_done, 1'b0);
        chk("tmo.pre_cyc", a_cyc, 32'd499);
        tick();
        retire = 1'b0;
        verdict("tmo", 1'b1, 1'b0, 1'b1, 1'b1, 32'd0);
        chk("tmo.cyc", a_cyc, 32'd500);
        chk("tmo.ret", a_ret, 32'd500);
        chk("tmo.busy", a_busy, 1'b0);

        // end write on the timeout edge wins
        pulse_start();
        repeat (499) tick();
        wr(5'd26, 32'd1);
        chk("tmo_end.done", a_done, 1'b0);
        chk("tmo_end.busy", a_busy, 1'b1);
        chk("tmo_end.cyc", a_cyc, 32'd500);
        tick();
        verdict("tmo_end", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("tmo_end.cyc2", a_cyc, 32'd501);

        // restart during SETTLE clears everything
        pulse_start();
        retire = 1'b1;
        wr(5'd3, 32'd9);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        retire = 1'b0;
        pulse_start();
        chk("rs.busy", a_busy, 1'b1);
        chk("rs.done", a_done, 1'b0);
        chk("rs.cyc", a_cyc, 32'd0);
        chk("rs.ret", a_ret, 32'd0);
        chk("rs.b_busy", b_busy, 1'b1);
        chk("rs.b_done", b_done, 1'b0);
        wr(5'd26, 32'd1);
        tick();
        verdict("rs", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);

        // reset mid-RUN, then idle writes ignored
        pulse_start();
        retire = 1'b1;
        wr(5'd3, 32'd4);
        retire = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst.busy", a_busy, 1'b0);
        verdict("mrst", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("mrst.cyc", a_cyc, 32'd0);
        chk("mrst.ret", a_ret, 32'd0);
        wr(5'd3, 32'd6);
        wr(5'd26, 32'd1);
        chk("mrst.idle_busy", a_busy, 1'b0);
        pulse_start();
        wr(5'd26, 32'd1);
        tick();
        verdict("mrst2", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
